sram_controller: RTL and testbench

//   Responder end of the cache<->SRAM link. Accepts one read or write request from
//   the cache controller and runs it on the board's asynchronous 256Kx16 SRAM.
//   A write stores one 32-bit word as two 16-bit halves. A read returns one
//   8-byte-aligned 64-bit block as four 16-bit halves. sram_ready stays low while
//   a request is in progress, so the pipeline stalls until the access completes.

---
 rtl/sram_pkg.sv | 9 +
 rtl/sram_controller.sv | 110 +++++++++++
 tb/tb_sram_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and sizes for the cache-side SRAM responder.
package sram_pkg;
    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DQ_W   = 16;
    localparam int WR_HALVES   = 2;
    localparam int RD_HALVES   = 4;
endpackage

// File: rtl/sram_controller.sv
// Runs one 32-bit write (two halves) or one 64-bit aligned read (four halves)
// on an asynchronous 256Kx16 SRAM, stalling the requester via sram_ready.
module sram_controller
    import sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sram_write,
    input  logic                   sram_read,
    input  logic [31:0]            sram_address,
    input  logic [31:0]            sram_wdata,
    output logic [63:0]            sram_rdata,
    output logic                   sram_ready,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);
    localparam int PH_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(ACCESS_CYCLES - 1);

    state_t          r_state;
    logic [PH_W-1:0] r_phase;
    logic [1:0]      r_half;
    logic [63:0]     r_rdata;

    logic                 w_last_phase;
    logic                 w_dq_drive;
    logic [SRAM_DQ_W-1:0] w_wr_half;
    logic                 w_unused;

    assign w_last_phase = (r_phase == PH_LAST);
    assign w_dq_drive   = (r_state == WR);
    assign w_wr_half    = r_half[0] ? sram_wdata[31:16] : sram_wdata[15:0];
    assign w_unused     = ^{sram_address[31:19], sram_address[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_half  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_phase <= '0;
                    r_half  <= '0;
                    if (sram_write)
                        r_state <= WR;
                    else if (sram_read)
                        r_state <= RD;
                end
                WR: begin
                    if (w_last_phase) begin
                        r_phase <= '0;
                        if (r_half == 2'(WR_HALVES - 1)) begin
                            r_half  <= '0;
                            r_state <= DONE;
                        end else begin
                            r_half <= r_half + 2'd1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                RD: begin
                    if (w_last_phase) begin
                        // Capture at the edge closing the half; data has had the full access time.
                        r_rdata[{r_half, 4'b0000} +: SRAM_DQ_W] <= SRAM_DQ;
                        r_phase <= '0;
                        if (r_half == 2'(RD_HALVES - 1)) begin
                            r_half  <= '0;
                            r_state <= DONE;
                        end else begin
                            r_half <= r_half + 2'd1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Address follows the live request; the last phase of a write half is WE_N recovery.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        if (r_state == WR) begin
            SRAM_ADDR = {sram_address[18:2], r_half[0]};
            SRAM_WE_N = w_last_phase;
        end else if (r_state == RD) begin
            SRAM_ADDR = {sram_address[18:3], r_half};
        end
    end

    assign SRAM_DQ    = w_dq_drive ? w_wr_half : {SRAM_DQ_W{1'bz}};
    assign sram_ready = ((r_state == IDLE) && !sram_read && !sram_write) || (r_state == DONE);
    assign sram_rdata = r_rdata;
    assign SRAM_UB_N  = 1'b0;
    assign SRAM_LB_N  = 1'b0;
    assign SRAM_CE_N  = 1'b0;
    assign SRAM_OE_N  = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// Scoreboarded random/directed bench for sram_controller with a behavioural SRAM.
module tb_sram_controller;
    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_wr = 1'b0;
    logic        req_rd = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    wire  [15:0] w_dq;
    logic [17:0] sram_addr;
    logic        we_n, ub_n, lb_n, ce_n, oe_n;

    sram_controller #(.ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst),
        .sram_write(req_wr), .sram_read(req_rd),
        .sram_address(req_addr), .sram_wdata(req_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .SRAM_DQ(w_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM: outputs stored data unless a write is in progress.
    logic [15:0] sram_mem [0:262143];
    assign w_dq = req_wr ? 16'bz : sram_mem[sram_addr];
    always @(posedge clk) if (we_n == 1'b0) sram_mem[sram_addr] <= w_dq;

    // Reference model: 32-bit words indexed by address bits [18:2].
    logic [31:0] ref_mem [int];
    logic [63:0] last_rd = '0;

    function automatic logic [31:0] ref_get(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [63:0] rdata;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [17:0] wr_seen_addr[$];
    logic [15:0] wr_seen_dq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks bus activity and pops the scoreboard on completion.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] hh;
        if (mon_en && !rst) begin
            if (!(req_wr || req_rd)) begin
                chk("idle_ready", 64'(sram_ready), 64'd1);
                chk("idle_we_n", 64'(we_n), 64'd1);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_request", 64'd1, 64'd0);
            end else begin
                e = exp_q[0];
                if (!e.is_wr) begin
                    chk("rd_we_n", 64'(we_n), 64'd1);
                    if (cyc >= 1 && cyc <= 4 * AC) begin
                        hh = 2'((cyc - 1) / AC);
                        chk("rd_addr", 64'(sram_addr), 64'({e.addr[18:3], hh}));
                    end
                end else if (we_n == 1'b0) begin
                    wr_seen_addr.push_back(sram_addr);
                    wr_seen_dq.push_back(w_dq);
                end
                if (sram_ready) begin
                    e = exp_q.pop_front();
                    chk("latency", 64'(cyc), 64'(e.lat));
                    chk("rdata", sram_rdata, e.rdata);
                    if (e.is_wr) begin
                        chk("wr_pulses", 64'(wr_seen_addr.size()), 64'(2 * (AC - 1)));
                        for (int i = 0; i < wr_seen_addr.size() && i < 2 * (AC - 1); i++) begin
                            hh = 2'(i / (AC - 1));
                            chk("wr_addr", 64'(wr_seen_addr[i]), 64'({e.addr[18:2], hh[0]}));
                            chk("wr_dq", 64'(wr_seen_dq[i]),
                                64'(hh[0] ? e.wdata[31:16] : e.wdata[15:0]));
                        end
                        wr_seen_addr.delete();
                        wr_seen_dq.delete();
                    end
                    cyc = 0;
                    done_cnt++;
                end else begin
                    cyc++;
                end
            end
        end
    end

    // Issue one request (caller sits just after a rising edge); returns just after DONE ends.
    task automatic issue(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int start;
        int idx;
        req_wr = wr; req_rd = rd; req_addr = a; req_wdata = d;
        e.is_wr = wr; e.addr = a; e.wdata = d;
        if (wr) begin
            ref_mem[int'(a[18:2])] = d;
            e.rdata = last_rd;
            e.lat = 2 * AC + 1;
        end else begin
            idx = int'({a[18:3], 1'b0});
            last_rd = {ref_get(idx + 1), ref_get(idx)};
            e.rdata = last_rd;
            e.lat = 4 * AC + 1;
        end
        exp_q.push_back(e);
        start = done_cnt;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            if (done_cnt != start) break;
        end
        if (done_cnt == start) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: no completion for addr %h", a);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $fatal(1, "transaction timeout");
        end
        #1;
    endtask

    task automatic go_idle(input int n);
        req_wr = 1'b0; req_rd = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(sram_ready), 64'd1);
        chk("rst_we_n", 64'(we_n), 64'd1);
        chk("rst_rdata", sram_rdata, 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_dq_released", 64'(w_dq), 64'(sram_mem[sram_addr]));
        @(posedge clk); #1;
        mon_en = 1'b1;

        issue(1, 0, 32'h0000_0010, 32'hDEAD_BEEF);
        go_idle(1);
        issue(1, 0, 32'h0000_0014, 32'h1111_2222);
        go_idle(2);
        issue(0, 1, 32'h0000_0014, 32'h0);
        chk("rd_block", sram_rdata, 64'h1111_2222_DEAD_BEEF);
        issue(1, 0, 32'h0000_0040, 32'h0BAD_F00D);
        chk("rdata_kept_after_wr", sram_rdata, 64'h1111_2222_DEAD_BEEF);
        go_idle(1);
        issue(1, 1, 32'h0000_0020, 32'hA5A5_5A5A);
        go_idle(1);
        issue(0, 1, 32'h0000_0020, 32'h0);
        chk("both_low_word", 64'(sram_rdata[31:0]), 64'h0000_0000_A5A5_5A5A);
        go_idle(1);

        // Reset during a read aborts immediately.
        mon_en = 1'b0;
        req_rd = 1'b1; req_addr = 32'h0000_0010;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_we_n", 64'(we_n), 64'd1);
        chk("abort_rdata", sram_rdata, 64'd0);
        chk("abort_addr", 64'(sram_addr), 64'd0);
        chk("abort_ready_held", 64'(sram_ready), 64'd0);
        chk("abort_dq_released", 64'(w_dq), 64'(sram_mem[sram_addr]));
        rst = 1'b0; req_rd = 1'b0;
        #1 chk("abort_ready_drop", 64'(sram_ready), 64'd1);
        @(posedge clk); #1;
        last_rd = '0;
        cyc = 0;
        mon_en = 1'b1;

        for (int t = 0; t < 40; t++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            a = $urandom;
            a[18:2] = 17'($urandom_range(0, 31));
            issue(op != 1 && op != 3, op != 0, a, $urandom);
            go_idle($urandom_range(0, 2));
        end
        go_idle(2);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
